// File: rtl/completion_returner.sv
// completion_returner
//   Retires back-end completions for the front-end overflow stopper. Reads are
//   tagged in issue order, may return out of order, and are delivered in issue
//   order on a valid/ready port. Writes retire one write_done per acknowledge.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   mapper_enable            mapper issues a request this cycle
//   the_mapper_req_type      request type (REQ_READ / REQ_WRITE)
//   alloc_tag                tag a read issued this cycle receives (tail, comb.)
//   rd_ret_valid/tag/data    back-end read return
//   out_valid/ready/data/tag in-order read delivery (out_* registered)
//   wr_ack_valid             back end acknowledges one write
//   read_done, write_done    one-cycle retire pulses for the stopper
//   protocol_error           sticky until reset
module completion_returner #(
   parameter int READ_ENTRIES      = 16,
   parameter int READ_ENTRIES_LOG  = 4,
   parameter int WRITE_ENTRIES     = 16,
   parameter int WRITE_ENTRIES_LOG = 4,
   parameter int DATA_WIDTH        = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        mapper_enable,
   input  logic                        the_mapper_req_type,
   output logic [READ_ENTRIES_LOG-1:0] alloc_tag,
   input  logic                        rd_ret_valid,
   input  logic [READ_ENTRIES_LOG-1:0] rd_ret_tag,
   input  logic [DATA_WIDTH-1:0]       rd_ret_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_WIDTH-1:0]       out_data,
   output logic [READ_ENTRIES_LOG-1:0] out_tag,
   input  logic                        wr_ack_valid,
   output logic                        read_done,
   output logic                        write_done,
   output logic                        protocol_error
);

   typedef enum logic {REQ_READ = 1'b0, REQ_WRITE = 1'b1} req_type_e;

   localparam logic [READ_ENTRIES_LOG:0]  RD_FULL = (READ_ENTRIES_LOG+1)'(READ_ENTRIES);
   localparam logic [WRITE_ENTRIES_LOG:0] WR_FULL = (WRITE_ENTRIES_LOG+1)'(WRITE_ENTRIES);

   logic [READ_ENTRIES_LOG-1:0]  head, tail, head_n;
   logic [READ_ENTRIES_LOG:0]    rd_count;
   logic [WRITE_ENTRIES_LOG:0]   wr_count;
   logic [READ_ENTRIES-1:0]      alloc_q, filled_q;
   logic [DATA_WIDTH-1:0]        mem [READ_ENTRIES];

   logic is_read, rd_full, wr_full, wr_empty;
   logic alloc_ok, ret_ok, pop, wr_issue, wr_ack_ok, err_now;
   logic ret_hits_head_n, nxt_valid;
   logic [DATA_WIDTH-1:0] nxt_data;

   assign alloc_tag = tail;

   always_comb begin
      is_read   = (req_type_e'(the_mapper_req_type) == REQ_READ);
      rd_full   = (rd_count == RD_FULL);
      wr_full   = (wr_count == WR_FULL);
      wr_empty  = (wr_count == '0);
      alloc_ok  = mapper_enable & is_read & ~rd_full;
      wr_issue  = mapper_enable & ~is_read & ~wr_full;
      wr_ack_ok = wr_ack_valid & ~wr_empty;
      ret_ok    = rd_ret_valid & alloc_q[rd_ret_tag] & ~filled_q[rd_ret_tag];
      pop       = out_valid & out_ready;
      err_now   = (mapper_enable & is_read & rd_full)
                | (mapper_enable & ~is_read & wr_full)
                | (rd_ret_valid & ~ret_ok)
                | (wr_ack_valid & wr_empty);
   end

   // out_valid/out_data are registered from the post-update head entry, so a
   // return lands at the same edge it is stored (visible next cycle) and a
   // filled successor keeps out_valid high for back-to-back delivery.
   always_comb begin
      head_n          = pop ? head + 1'b1 : head;
      ret_hits_head_n = ret_ok & (rd_ret_tag == head_n);
      nxt_valid       = (filled_q[head_n] & ~(pop & (head_n == head))) | ret_hits_head_n;
      nxt_data        = ret_hits_head_n ? rd_ret_data : mem[head_n];
   end

   always_ff @(posedge clk) begin
      if (ret_ok) mem[rd_ret_tag] <= rd_ret_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head           <= '0;
         tail           <= '0;
         rd_count       <= '0;
         wr_count       <= '0;
         alloc_q        <= '0;
         filled_q       <= '0;
         out_valid      <= 1'b0;
         out_data       <= '0;
         out_tag        <= '0;
         read_done      <= 1'b0;
         write_done     <= 1'b0;
         protocol_error <= 1'b0;
      end else begin
         if (pop) begin
            alloc_q[head]  <= 1'b0;
            filled_q[head] <= 1'b0;
         end
         if (alloc_ok) alloc_q[tail]      <= 1'b1;
         if (ret_ok)   filled_q[rd_ret_tag] <= 1'b1;
         if (alloc_ok) tail <= tail + 1'b1;
         head <= head_n;

         case ({alloc_ok, pop})
            2'b10:   rd_count <= rd_count + 1'b1;
            2'b01:   rd_count <= rd_count - 1'b1;
            default: rd_count <= rd_count;
         endcase
         case ({wr_issue, wr_ack_ok})
            2'b10:   wr_count <= wr_count + 1'b1;
            2'b01:   wr_count <= wr_count - 1'b1;
            default: wr_count <= wr_count;
         endcase

         out_valid <= nxt_valid;
         out_tag   <= head_n;
         if (nxt_valid) out_data <= nxt_data;

         read_done  <= pop;
         write_done <= wr_ack_ok;
         if (err_now) protocol_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_completion_returner.sv
// Directed bench for completion_returner. Stimulus pushes expected deliveries
// into a scoreboard; a negedge monitor pops and compares on every handshake
// and checks each read_done pulse one cycle after its handshake.
module tb_completion_returner;
   localparam int RL = 4;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          mapper_enable, req_type, rd_ret_valid, out_ready, wr_ack_valid;
   logic [RL-1:0] rd_ret_tag, alloc_tag, out_tag;
   logic [DW-1:0] rd_ret_data, out_data;
   logic          out_valid, read_done, write_done, protocol_error;

   completion_returner #(
      .READ_ENTRIES(16), .READ_ENTRIES_LOG(RL),
      .WRITE_ENTRIES(16), .WRITE_ENTRIES_LOG(4), .DATA_WIDTH(DW)
   ) dut (
      .clk(clk), .rst(rst), .mapper_enable(mapper_enable),
      .the_mapper_req_type(req_type), .alloc_tag(alloc_tag),
      .rd_ret_valid(rd_ret_valid), .rd_ret_tag(rd_ret_tag), .rd_ret_data(rd_ret_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
      .wr_ack_valid(wr_ack_valid), .read_done(read_done), .write_done(write_done),
      .protocol_error(protocol_error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [RL-1:0] tag;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   logic rd_pend = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         rd_pend = 1'b0;
      end else begin
         if (rd_pend || read_done) check("read_done", 32'(read_done), 32'(rd_pend));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_delivery: data %0h tag %0h with nothing expected",
                        out_data, out_tag);
            end else begin
               mon_e = sb.pop_front();
               check("out_data", 32'(out_data), 32'(mon_e.data));
               check("out_tag", 32'(out_tag), 32'(mon_e.tag));
            end
         end
         rd_pend = out_valid && out_ready;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      mapper_enable = 1'b0; rd_ret_valid = 1'b0; wr_ack_valid = 1'b0; out_ready = 1'b0;
      rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic issue_read(input int exp_tag);
      check("alloc_tag", 32'(alloc_tag), 32'(exp_tag));
      mapper_enable = 1'b1; req_type = 1'b0;
      tick();
      mapper_enable = 1'b0;
   endtask

   task automatic ret(input logic [RL-1:0] tag, input logic [DW-1:0] data);
      rd_ret_valid = 1'b1; rd_ret_tag = tag; rd_ret_data = data;
      tick();
      rd_ret_valid = 1'b0;
   endtask

   task automatic push(input logic [DW-1:0] data, input logic [RL-1:0] tag);
      exp_t e;
      e.data = data; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic wait_valid(input string name);
      for (int i = 0; i < 20 && !out_valid; i++) tick();
      check(name, 32'(out_valid), 32'd1);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
      check(name, sb.size(), 0);
      tick(); tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; mapper_enable = 1'b0; req_type = 1'b0; rd_ret_valid = 1'b0;
      rd_ret_tag = '0; rd_ret_data = '0; out_ready = 1'b0; wr_ack_valid = 1'b0;
      tick();
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_out_tag", 32'(out_tag), 0);
      check("rst_read_done", 32'(read_done), 0);
      check("rst_write_done", 32'(write_done), 0);
      check("rst_error", 32'(protocol_error), 0);
      check("rst_alloc_tag", 32'(alloc_tag), 0);
      rst = 1'b1;
      tick();

      // Out-of-order return, in-order back-to-back delivery
      for (int i = 0; i < 3; i++) issue_read(i);
      push(16'hA000, 0); push(16'hA001, 1); push(16'hA002, 2);
      out_ready = 1'b1;
      ret(2, 16'hA002);
      ret(0, 16'hA000);
      ret(1, 16'hA001);
      check("b2b_valid1", 32'(out_valid), 1);
      check("b2b_data1", 32'(out_data), 32'hA001);
      tick();
      check("b2b_valid2", 32'(out_valid), 1);
      check("b2b_data2", 32'(out_data), 32'hA002);
      drain("drain_ooo");

      // Full window, overflow issue, pop while full then tag 0 reused
      do_reset();
      for (int i = 0; i < 16; i++) issue_read(i);
      check("full_no_err", 32'(protocol_error), 0);
      issue_read(0);
      check("overflow_err", 32'(protocol_error), 1);
      check("overflow_tail", 32'(alloc_tag), 0);
      push(16'hB000, 0);
      ret(0, 16'hB000);
      wait_valid("full_pop_valid");
      mapper_enable = 1'b1; req_type = 1'b0; out_ready = 1'b1;
      tick();
      mapper_enable = 1'b0; out_ready = 1'b0;
      check("full_pop_blocked_tail", 32'(alloc_tag), 0);
      issue_read(0);
      check("tag0_reused", 32'(alloc_tag), 1);
      drain("drain_full");

      // Back-pressure: output held stable, no pulse until accepted
      do_reset();
      issue_read(0);
      ret(0, 16'hC0C0);
      wait_valid("bp_valid");
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_valid", 32'(out_valid), 1);
         check("bp_hold_data", 32'(out_data), 32'hC0C0);
         check("bp_no_done", 32'(read_done), 0);
         tick();
      end
      push(16'hC0C0, 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_done_pulse", 32'(read_done), 1);
      tick();
      check("bp_done_single", 32'(read_done), 0);
      drain("drain_bp");

      // Writes: 4 issues, simultaneous issue+ack, 4 acks, ack at zero
      check("wr_pre_err", 32'(protocol_error), 0);
      mapper_enable = 1'b1; req_type = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      wr_ack_valid = 1'b1;
      tick();
      check("wd_simul", 32'(write_done), 1);
      mapper_enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("wd_pulse", 32'(write_done), 1);
      end
      wr_ack_valid = 1'b0;
      tick();
      check("wd_idle", 32'(write_done), 0);
      check("wd_no_err_yet", 32'(protocol_error), 0);
      wr_ack_valid = 1'b1;
      tick();
      wr_ack_valid = 1'b0;
      check("wd_ack_at_zero", 32'(write_done), 0);
      check("wd_ack_err", 32'(protocol_error), 1);
      tick();

      // Duplicate return to tag 3: first data kept
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) issue_read(i);
      push(16'hD000, 0); push(16'hD001, 1); push(16'hD002, 2); push(16'hD003, 3);
      ret(3, 16'hD003);
      check("dup_pre_err", 32'(protocol_error), 0);
      ret(3, 16'hE003);
      check("dup_err", 32'(protocol_error), 1);
      ret(0, 16'hD000);
      ret(1, 16'hD001);
      ret(2, 16'hD002);
      drain("drain_dup");

      // Asynchronous reset with reads outstanding
      do_reset();
      for (int i = 0; i < 5; i++) issue_read(i);
      ret(0, 16'hF000);
      ret(1, 16'hF001);
      ret(6, 16'hF006);
      check("unalloc_ret_err", 32'(protocol_error), 1);
      check("pre_rst_valid", 32'(out_valid), 1);
      #2 rst = 1'b0;
      #1;
      check("async_out_valid", 32'(out_valid), 0);
      check("async_out_data", 32'(out_data), 0);
      check("async_out_tag", 32'(out_tag), 0);
      check("async_read_done", 32'(read_done), 0);
      check("async_error", 32'(protocol_error), 0);
      out_ready = 1'b1;
      tick(); tick();
      rst = 1'b1;
      tick();
      check("post_rst_alloc_tag", 32'(alloc_tag), 0);
      for (int i = 0; i < 4; i++) begin
         check("post_rst_no_done", 32'(read_done), 0);
         tick();
      end
      check("post_rst_valid", 32'(out_valid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
